// File: rtl/ins_seq.sv
// Instruction sequencer: fetches a word from instruction memory, hands it to the
// decoder, issues it to the execute unit and advances the PC, until a HALT opcode.
module ins_seq #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   imem_req_valid_o,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr_o,
    input  logic                   imem_req_ready_i,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic [INSTR_WIDTH-1:0] dec_instr_o,
    output logic                   dec_valid_o,
    input  logic                   dec_halt_i,
    input  logic                   dec_branch_i,
    input  logic [ADDR_WIDTH-1:0]  dec_target_i,
    output logic                   exe_valid_o,
    input  logic                   exe_ready_i,
    input  logic                   exe_taken_i,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   busy_o,
    output logic                   halted_o,
    output logic [15:0]            retired_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_V = ADDR_WIDTH'(RESET_PC);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [15:0]            retired_q, retired_d;
    logic                   br_q;
    logic [ADDR_WIDTH-1:0]  tgt_q;
    logic                   capture;
    logic                   exe_fire;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Taken branches jump to the target captured at decode; everything else falls through.
    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc,
                                                     input logic                  br,
                                                     input logic                  taken,
                                                     input logic [ADDR_WIDTH-1:0] tgt);
        return (br && taken) ? tgt : pc + ADDR_WIDTH'(1);
    endfunction

    assign capture  = (state_q == S_WAIT) && imem_rsp_valid_i;
    assign exe_fire = (state_q == S_EXEC) && exe_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i)          state_d = S_FETCH;
            S_FETCH:  if (imem_req_ready_i) state_d = S_WAIT;
            S_WAIT:   if (imem_rsp_valid_i) state_d = S_DECODE;
            S_DECODE: state_d = dec_halt_i ? S_HALT : S_EXEC;
            S_EXEC:   if (exe_ready_i)      state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid_o = 1'b0;
        dec_valid_o      = 1'b0;
        exe_valid_o      = 1'b0;
        busy_o           = 1'b0;
        halted_o         = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_valid_o = 1'b1;
                busy_o           = 1'b1;
            end
            S_WAIT:   busy_o = 1'b1;
            S_DECODE: begin
                dec_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_EXEC: begin
                exe_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_HALT:   halted_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        if (capture) begin
            ir_d = imem_rsp_data_i;
        end
        if (exe_fire) begin
            pc_d      = next_pc(pc_q, br_q, exe_taken_i, tgt_q);
            retired_d = sat_inc(retired_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC_V;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Branch info is only meaningful in EXEC, so it is captured without reset.
    always_ff @(posedge clk_i) begin
        if (state_q == S_DECODE) begin
            br_q  <= dec_branch_i;
            tgt_q <= dec_target_i;
        end
    end

    assign imem_req_addr_o = pc_q;
    assign pc_o            = pc_q;
    assign dec_instr_o     = ir_q;
    assign retired_o       = retired_q;

endmodule

// File: tb/tb_ins_seq.sv
// Bench for ins_seq: program memory, decoder and execute responders, a program-level
// reference model feeding an expectation queue, and a monitor that checks the DUT.
module tb_ins_seq;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [7:0]  imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i, dec_instr_o;
    logic        dec_valid_o, dec_halt_i, dec_branch_i;
    logic [7:0]  dec_target_i, pc_o;
    logic        exe_valid_o, exe_ready_i, exe_taken_i;
    logic        busy_o, halted_o;
    logic [15:0] retired_o;

    ins_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .dec_instr_o(dec_instr_o),
        .dec_valid_o(dec_valid_o), .dec_halt_i(dec_halt_i), .dec_branch_i(dec_branch_i),
        .dec_target_i(dec_target_i), .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
        .exe_taken_i(exe_taken_i), .pc_o(pc_o), .busy_o(busy_o), .halted_o(halted_o),
        .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction encoding used by the bench: [31] HALT, [30] branch, [29] taken, [7:0] target.
    localparam logic [31:0] HALT_W = 32'h8000_0000;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] instr;
        logic        halt;
        int          ret;
    } rec_t;

    logic [31:0] mem [256];
    rec_t        exp_q[$];
    rec_t        cur;
    bit          has_cur, halt_seen, last_halt;
    int          fetch_cnt, exp_total;
    int          n_cmp, n_fail;

    bit manual, rdy_rand, rsp_rand, exe_rand;
    int stall_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: walk the program from the reset PC and list every fetch it implies.
    task automatic build(input int limit);
        int          pc, ret;
        logic [31:0] w;
        exp_q.delete();
        pc = 0; ret = 0; last_halt = 1'b0;
        for (int i = 0; i < limit; i++) begin
            w = mem[pc];
            exp_q.push_back('{addr: 8'(pc), instr: w, halt: w[31], ret: ret});
            if (w[31]) begin
                last_halt = 1'b1;
                break;
            end
            ret = (ret == 65535) ? ret : ret + 1;
            pc  = (w[30] && w[29]) ? int'(w[7:0]) : (pc + 1) % 256;
        end
        exp_total = exp_q.size();
        fetch_cnt = 0; halt_seen = 1'b0; has_cur = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = {3'b000, 29'($urandom)};
    endtask

    // Memory, decoder and execute responders.
    initial begin
        bit         pending, acc;
        logic [7:0] paddr;
        pending = 0; acc = 0; paddr = '0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        dec_halt_i = 1'b0; dec_branch_i = 1'b0; dec_target_i = '0;
        exe_ready_i = 1'b0; exe_taken_i = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (!manual) begin
                if (rst_i) pending = 0;
                else if (acc) pending = 1;
                if (pending && !rst_i && (!rsp_rand || ($urandom % 3) != 0)) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = mem[paddr];
                    pending          = 0;
                end else if (pending) begin
                    imem_rsp_valid_i = 1'b0;
                    imem_rsp_data_i  = $urandom;
                end else begin
                    imem_rsp_valid_i = rsp_rand && (($urandom % 5) == 0);
                    imem_rsp_data_i  = $urandom;
                end
                if (stall_n > 0 && imem_req_valid_o) begin
                    imem_req_ready_i = 1'b0;
                    stall_n--;
                end else begin
                    imem_req_ready_i = !rdy_rand || (($urandom % 3) != 0);
                end
                acc   = imem_req_valid_o && imem_req_ready_i && !rst_i;
                paddr = imem_req_addr_o;
                if (dec_valid_o) begin
                    dec_halt_i   = dec_instr_o[31];
                    dec_branch_i = dec_instr_o[30];
                    dec_target_i = dec_instr_o[7:0];
                end else begin
                    dec_halt_i   = 1'($urandom);
                    dec_branch_i = 1'($urandom);
                    dec_target_i = 8'($urandom);
                end
                exe_ready_i = !exe_rand || 1'($urandom);
                exe_taken_i = (exe_valid_o && exe_ready_i) ? dec_instr_o[29] : 1'($urandom);
            end else begin
                acc = 0; pending = 0;
            end
        end
    end

    // Monitor: pops one expectation per accepted fetch and follows it through decode/exec/halt.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_i) begin
                has_cur = 1'b0;
            end else begin
                if (imem_req_valid_o && imem_req_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("fetch_unexpected", {24'b0, imem_req_addr_o}, 32'hFFFF_FFFF);
                        has_cur = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        has_cur = 1'b1;
                        fetch_cnt++;
                        chk("fetch_addr", {24'b0, imem_req_addr_o}, {24'b0, cur.addr});
                        chk("fetch_pc", {24'b0, pc_o}, {24'b0, cur.addr});
                        chk("fetch_retired", {16'b0, retired_o}, 32'(cur.ret));
                    end
                end
                if (dec_valid_o && has_cur) chk("dec_instr", dec_instr_o, cur.instr);
                if (exe_valid_o && has_cur) chk("exe_on_halt", {31'b0, cur.halt}, 32'd0);
                if (halted_o && has_cur && !halt_seen) begin
                    halt_seen = 1'b1;
                    chk("halt_expected", {31'b0, cur.halt}, 32'd1);
                    chk("halt_retired", {16'b0, retired_o}, 32'(cur.ret));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        tick(); rst_i = 1'b1;
        tick(); rst_i = 1'b0;
    endtask

    task automatic pulse_start();
        tick(); start_i = 1'b1;
        tick(); start_i = 1'b0;
    endtask

    task automatic run_wait(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            tick(); #3;
            if (halted_o || (fetch_cnt >= exp_total && !last_halt)) done = 1;
        end
        if (!done) chk("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_i = 1'b1; start_i = 1'b0;
        manual = 0; rdy_rand = 0; rsp_rand = 0; exe_rand = 0; stall_n = 0;
        clear_mem();
        build(0);
        tick(); tick(); rst_i = 1'b0;
        tick(); #3;
        chk("rst_pc", {24'b0, pc_o}, 32'd0);
        chk("rst_retired", {16'b0, retired_o}, 32'd0);
        chk("rst_ir", dec_instr_o, 32'd0);
        chk("rst_flags", {27'b0, busy_o, halted_o, imem_req_valid_o, dec_valid_o, exe_valid_o}, 32'd0);

        // Three NOPs then HALT, zero-wait responders.
        clear_mem(); mem[3] = HALT_W; build(10);
        pulse_start();
        repeat (12) @(posedge clk_i);
        #1;
        chk("nop_pc_12cyc", {24'b0, pc_o}, 32'd3);
        chk("nop_retired_12cyc", {16'b0, retired_o}, 32'd3);
        run_wait(100);
        chk("nop_halted", {31'b0, halted_o}, 32'd1);
        do_reset();

        // Memory not ready for 5 cycles.
        clear_mem(); mem[1] = HALT_W; build(10);
        stall_n = 5;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #3;
            chk("stall_hold", {23'b0, imem_req_valid_o, imem_req_addr_o}, {23'b0, 1'b1, 8'h00});
            chk("stall_state", {30'b0, busy_o, dec_valid_o}, 32'd2);
        end
        run_wait(100);
        chk("stall_retired", {16'b0, retired_o}, 32'd1);
        do_reset();

        // Taken and not-taken branch at pc=2.
        clear_mem(); mem[2] = 32'h6000_0040; mem[8'h40] = HALT_W; build(10);
        pulse_start(); run_wait(200);
        chk("br_taken_pc", {24'b0, pc_o}, 32'h40);
        do_reset();
        clear_mem(); mem[2] = 32'h4000_0040; mem[3] = HALT_W; mem[8'h40] = HALT_W; build(10);
        pulse_start(); run_wait(200);
        chk("br_not_taken_pc", {24'b0, pc_o}, 32'd3);
        chk("br_not_taken_ret", {16'b0, retired_o}, 32'd3);
        do_reset();

        // PC wraps 0xFF -> 0x00.
        clear_mem(); mem[0] = 32'h6000_00FE; build(6);
        pulse_start(); run_wait(200);
        chk("wrap_pc", {24'b0, pc_o}, 32'hFF);
        chk("wrap_retired", {16'b0, retired_o}, 32'd5);
        do_reset();

        // HALT at pc=5 is sticky; start ignored; reset leaves it.
        clear_mem(); mem[5] = HALT_W; build(10);
        pulse_start(); run_wait(200);
        chk("halt_pc", {24'b0, pc_o}, 32'd5);
        chk("halt_retired5", {16'b0, retired_o}, 32'd5);
        chk("halt_busy", {30'b0, busy_o, halted_o}, 32'd1);
        pulse_start();
        repeat (5) tick();
        #3;
        chk("halt_sticky", {30'b0, halted_o, imem_req_valid_o}, 32'd2);
        chk("halt_ret_hold", {16'b0, retired_o}, 32'd5);
        do_reset(); #3;
        chk("halt_rst_pc", {24'b0, pc_o}, 32'd0);
        chk("halt_rst_flags", {30'b0, busy_o, halted_o}, 32'd0);

        // Reset in WAIT while a response arrives.
        clear_mem(); build(1);
        manual = 1;
        tick(); imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0;
        pulse_start();
        tick(); imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h1234_5678; rst_i = 1'b1;
        tick(); imem_rsp_valid_i = 1'b0; rst_i = 1'b0; #3;
        chk("rstwait_ir", dec_instr_o, 32'd0);
        chk("rstwait_flags", {27'b0, busy_o, halted_o, imem_req_valid_o, dec_valid_o, exe_valid_o}, 32'd0);
        tick(); #3;
        chk("rstwait_idle", {30'b0, busy_o, imem_req_valid_o}, 32'd0);
        manual = 0;
        do_reset();

        // Random programs with random handshake timing.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                logic [31:0] w;
                w = $urandom;
                w[31] = (($urandom % 24) == 0);
                w[30] = (($urandom % 3) == 0);
                mem[i] = w;
            end
            rdy_rand = 1; rsp_rand = 1; exe_rand = 1;
            build(40);
            pulse_start();
            run_wait(3000);
            rdy_rand = 0; rsp_rand = 0; exe_rand = 0;
            do_reset();
        end

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ins_seq.md
INS_SEQ -- requirements
Module: ins_seq

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, instruction address width in words.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 The block SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begins sequencing from IDLE.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_addr_o  out  ADDR_WIDTH  fetch address, equal to pc_o.
- imem_req_ready_i  in  1  memory accepts request.
- imem_rsp_valid_i  in  1  instruction data valid.
- imem_rsp_data_i  in  INSTR_WIDTH  instruction word.
- dec_instr_o  out  INSTR_WIDTH  captured instruction register (IR) to decoder.
- dec_valid_o  out  1  IR valid for decode, one cycle.
- dec_halt_i  in  1  decoder reports HALT opcode.
- dec_branch_i  in  1  decoder reports branch/jump.
- dec_target_i  in  ADDR_WIDTH  branch target.
- exe_valid_o  out  1  instruction issued to execute unit.
- exe_ready_i  in  1  execute unit accepts.
- exe_taken_i  in  1  branch taken, sampled at the execute handshake.
- pc_o  out  ADDR_WIDTH  current PC.
- busy_o  out  1  high in any state except IDLE and HALT.
- halted_o  out  1  high in HALT.
- retired_o  out  16  retired-instruction count.

Function
REQ-006 The FSM SHALL have states IDLE, FETCH, WAIT, DECODE, EXEC and HALT, each with a one-hot or encoded register.
REQ-007 IDLE SHALL hold all strobes low and move to FETCH on start_i=1; start_i SHALL be ignored in every other state.
REQ-008 FETCH SHALL assert imem_req_valid_o with imem_req_addr_o=pc_o and move to WAIT in the cycle after imem_req_valid_o & imem_req_ready_i; the request SHALL stay stable until accepted.
REQ-009 WAIT SHALL load IR from imem_rsp_data_i on imem_rsp_valid_i=1 and then move to DECODE; imem_rsp_valid_i SHALL be ignored outside WAIT.
REQ-010 DECODE SHALL assert dec_valid_o for exactly one cycle and sample dec_halt_i, dec_branch_i and dec_target_i in that cycle.
REQ-011 From DECODE, dec_halt_i=1 SHALL go to HALT, with no execute issue and no retired increment; otherwise the FSM SHALL go to EXEC.
REQ-012 EXEC SHALL hold exe_valid_o=1 until exe_ready_i=1; on that handshake cycle:
- the FSM SHALL return to FETCH;
- retired_o SHALL increment, saturating at 0xFFFF;
- the PC SHALL update per REQ-013.
REQ-013 The PC SHALL update as follows:
- if the sampled branch=1 and exe_taken_i=1, pc SHALL load the sampled target;
- otherwise pc SHALL become pc+1 modulo 2^ADDR_WIDTH (0xFF -> 0x00 at default width).
REQ-014 dec_instr_o SHALL always reflect IR and change only at the WAIT capture.
REQ-015 HALT SHALL be sticky; only rst_i SHALL leave it.
REQ-016 Minimum latency SHALL be 4 cycles per instruction (FETCH, WAIT, DECODE, EXEC), with zero-wait memory and execute unit.
REQ-017 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-018 When rst_i=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, IR=0, retired=0, and all valid outputs, busy_o and halted_o to 0.
REQ-019 Reset SHALL take priority over every transition, including mid-handshake; a pending memory request SHALL be dropped without completion.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, then start_i pulse, 3 NOP instructions, zero-wait responders: pc_o steps 0->1->2->3 and retired_o=3 after 12 cycles.
- imem_req_ready_i held low 5 cycles: imem_req_valid_o and addr held stable; FSM stays in FETCH.
- Branch at pc=2 with target 0x40 and exe_taken_i=1: next fetch addr=0x40; with exe_taken_i=0: next fetch addr=3.
- pc=0xFF with a non-branch instruction: next fetch addr=0x00.
- HALT at pc=5: halted_o=1, exe_valid_o never asserts, retired unchanged; start_i ignored; rst_i returns to IDLE with pc=0.
- rst_i asserted in WAIT with a response arriving in the same cycle: IR stays 0 and state=IDLE.
